// File: rtl/stream_mux_pkg.sv
// Shared constants and helpers for the stream_mux_rr block.
package stream_mux_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // Index width that never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stream_mux_rr_grant.sv
// Round-robin grant: first requester at or after ptr, wrapping modulo N_CH.
module rr_grant
  import stream_mux_pkg::*;
#(
  parameter  int N_CH  = 4,
  localparam int SEL_W = clog2_min1(N_CH)
) (
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] ptr,
  output logic [N_CH-1:0]  grant,
  output logic [SEL_W-1:0] gidx
);

  logic found;

  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      int c;
      c = int'(ptr) + k;
      if (c >= N_CH) c = c - N_CH;
      if (!found && req[c]) begin
        found    = 1'b1;
        grant[c] = 1'b1;
        gidx     = SEL_W'(c);
      end
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream mux with fixed-select or round-robin arbitration
// and a single registered output stage.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter  int N_CH  = 4,
  parameter  int WIDTH = 8,
  parameter  int MODE  = MODE_FIXED,
  localparam int SEL_W = clog2_min1(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH*WIDTH-1:0] in_data,
  input  logic [N_CH-1:0]       in_valid,
  output logic [N_CH-1:0]       in_ready,
  input  logic [SEL_W-1:0]      sel,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SEL_W-1:0]      out_ch
);

  logic             load;
  logic             gany;
  logic [N_CH-1:0]  grant;
  logic [SEL_W-1:0] gidx;
  logic [WIDTH-1:0] gdata;

  assign load = !out_valid || out_ready;
  assign gany = |grant;
  // No handshake is offered while reset is held.
  assign in_ready = (!rst && load) ? grant : '0;

  generate
    if (MODE == MODE_RR) begin : g_rr
      logic [SEL_W-1:0] ptr;
      logic             sel_unused;

      assign sel_unused = ^sel;

      rr_grant #(.N_CH(N_CH)) u_rr (
        .req   (in_valid),
        .ptr   (ptr),
        .grant (grant),
        .gidx  (gidx)
      );

      always_ff @(posedge clk) begin
        if (rst)
          ptr <= '0;
        else if (load && gany)
          ptr <= (int'(gidx) == N_CH - 1) ? '0 : gidx + 1'b1;
      end
    end else begin : g_fixed
      // Out-of-range sel matches no lane, so it yields no grant.
      always_comb begin
        grant = '0;
        gidx  = sel;
        for (int i = 0; i < N_CH; i++)
          grant[i] = (int'(sel) == i) && in_valid[i];
      end
    end
  endgenerate

  always_comb begin
    gdata = '0;
    for (int i = 0; i < N_CH; i++)
      if (grant[i]) gdata = gdata | in_data[i*WIDTH +: WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (load) begin
      if (gany) begin
        out_valid <= 1'b1;
        out_data  <= gdata;
        out_ch    <= gidx;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Scoreboard bench: fixed-select mux (5 ch) and round-robin mux (4 ch) driven side by side.
module tb_stream_mux_rr;

  localparam int N0 = 5;
  localparam int N1 = 4;
  localparam int W  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [N0*W-1:0] d0;
  logic [N0-1:0]   v0, r0;
  logic [2:0]      sel0, oc0;
  logic [W-1:0]    od0;
  logic            ov0, ordy0;

  logic [N1*W-1:0] d1;
  logic [N1-1:0]   v1, r1;
  logic [1:0]      sel1, oc1;
  logic [W-1:0]    od1;
  logic            ov1, ordy1;

  stream_mux_rr #(.N_CH(N0), .WIDTH(W), .MODE(0)) u_fix (
    .clk(clk), .rst(rst), .in_data(d0), .in_valid(v0), .in_ready(r0), .sel(sel0),
    .out_data(od0), .out_valid(ov0), .out_ready(ordy0), .out_ch(oc0));

  stream_mux_rr #(.N_CH(N1), .WIDTH(W), .MODE(1)) u_rr (
    .clk(clk), .rst(rst), .in_data(d1), .in_valid(v1), .in_ready(r1), .sel(sel1),
    .out_data(od1), .out_valid(ov1), .out_ready(ordy1), .out_ch(oc1));

  typedef struct { logic [7:0] data; int ch; } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  int         vectors = 0;
  int         miscompares = 0;
  bit         chk_en = 1'b0;
  bit         mv[2];
  int         ptr[2];
  bit         pend_clr[2];
  logic [7:0] exp_rdy[2];
  logic       exp_ov[2];

  task automatic check(input int d, input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL dut%0d %s: got %h expected %h at %0t", d, nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] chdat(input int d, input int i);
    return d ? d1[i*W +: W] : d0[i*W +: W];
  endfunction

  // Transaction-level model: decides this cycle's grant from the rules and
  // queues the word the DUT must present from the next cycle on.
  task automatic model_step(input int d);
    int nch, g, s;
    logic [7:0] vv;
    logic orr, ld;
    exp_t e;
    nch = d ? N1 : N0;
    vv  = d ? 8'(v1) : 8'(v0);
    orr = d ? ordy1 : ordy0;
    if (pend_clr[d]) begin
      if (d) q1.delete(); else q0.delete();
      pend_clr[d] = 1'b0;
    end
    exp_ov[d] = mv[d];
    ld = !mv[d] || orr;
    g = -1;
    if (d == 0) begin
      s = int'(sel0);
      if (s < nch && vv[s]) g = s;
    end else begin
      for (int k = 0; k < nch; k++)
        if (g < 0 && vv[(ptr[d] + k) % nch]) g = (ptr[d] + k) % nch;
    end
    exp_rdy[d] = (!rst && ld && g >= 0) ? (8'd1 << g) : 8'd0;
    if (rst) begin
      mv[d] = 1'b0; ptr[d] = 0; pend_clr[d] = 1'b1;
    end else if (ld) begin
      if (g >= 0) begin
        e.data = chdat(d, g); e.ch = g;
        if (d) q1.push_back(e); else q0.push_back(e);
        mv[d] = 1'b1;
        ptr[d] = (g + 1) % nch;
      end else begin
        mv[d] = 1'b0;
      end
    end
  endtask

  task automatic mon(input int d);
    logic [7:0] rdy, od, oc;
    logic ov, orr;
    exp_t e;
    int qs;
    if (d == 0) begin rdy = 8'(r0); ov = ov0; od = od0; oc = 8'(oc0); orr = ordy0; qs = q0.size(); end
    else        begin rdy = 8'(r1); ov = ov1; od = od1; oc = 8'(oc1); orr = ordy1; qs = q1.size(); end
    check(d, "in_ready", 32'(rdy), 32'(exp_rdy[d]));
    check(d, "out_valid", 32'(ov), 32'(exp_ov[d]));
    if (ov === 1'b1) begin
      if (qs == 0) begin
        vectors++; miscompares++;
        $display("FAIL dut%0d unexpected_word: got %h ch %0d, expected none at %0t", d, od, oc, $time);
      end else begin
        e = d ? q1[0] : q0[0];
        check(d, "out_data", 32'(od), 32'(e.data));
        check(d, "out_ch", 32'(oc), 32'(e.ch));
        if (orr === 1'b1) begin
          if (d) void'(q1.pop_front()); else void'(q0.pop_front());
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      mon(0);
      mon(1);
    end
  end

  task automatic tick();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; v0 = '1; v1 = '1; ordy0 = 1'b1; ordy1 = 1'b1; sel0 = '0; sel1 = '0;
    d0 = 40'({$urandom, $urandom}); d1 = 32'($urandom);
    mv = '{1'b0, 1'b0}; ptr = '{0, 0}; pend_clr = '{1'b0, 1'b0};
    tick();
    chk_en = 1'b1;
    tick();
    check(0, "rst_out_data", 32'(od0), 32'h0);
    check(0, "rst_out_ch",   32'(oc0), 32'h0);
    check(1, "rst_out_data", 32'(od1), 32'h0);
    check(1, "rst_out_ch",   32'(oc1), 32'h0);
    rst = 1'b0;

    // Fixed-select directed steps alongside eight cycles of round-robin fairness.
    d1 = {8'h40, 8'h30, 8'h20, 8'h10};
    for (int k = 0; k < 8; k++) begin
      if (k == 0) begin v0 = 5'b00100; sel0 = 3'd2; d0[2*W +: W] = 8'hA5; end
      else if (k == 1) sel0 = 3'd3;
      else if (k == 2) begin sel0 = 3'd6; v0 = '1; end
      else sel0 = 3'(k % N0);
      tick();
      if (k == 0) begin
        check(0, "sel2_data", 32'(od0), 32'hA5);
        check(0, "sel2_ch",   32'(oc0), 32'd2);
      end
      if (k == 1) check(0, "sel3_idle_valid", 32'(ov0), 32'd0);
      if (k == 2) check(0, "sel_oor_valid", 32'(ov0), 32'd0);
      check(1, "rr_seq_data", 32'(od1), 32'(8'h10 * (k % 4 + 1)));
      check(1, "rr_seq_ch",   32'(oc1), 32'(k % 4));
      check(1, "rr_seq_valid", 32'(ov1), 32'd1);
    end

    // Backpressure on a held 3C word while inputs and sel churn.
    for (int i = 0; i < N0; i++) d0[i*W +: W] = 8'h3C;
    for (int i = 0; i < N1; i++) d1[i*W +: W] = 8'h3C;
    sel0 = 3'd1;
    tick();
    ordy0 = 1'b0; ordy1 = 1'b0;
    repeat (5) begin
      d0 = 40'({$urandom, $urandom}); d1 = 32'($urandom); sel0 = 3'($urandom_range(0, 4));
      tick();
      check(0, "hold_data", 32'(od0), 32'h3C);
      check(1, "hold_data", 32'(od1), 32'h3C);
    end
    ordy0 = 1'b1; ordy1 = 1'b1;
    tick();

    // Round-robin wrap from ptr=3.
    v1 = 4'b0100; tick();
    v1 = 4'b0011; tick();
    check(1, "wrap_ch0", 32'(oc1), 32'd0);
    tick();
    check(1, "wrap_ch1", 32'(oc1), 32'd1);

    // Mid-stream reset with a held word and ptr=2.
    v1 = 4'b0010; tick();
    ordy1 = 1'b0; tick();
    rst = 1'b1; tick();
    check(1, "mid_rst_valid", 32'(ov1), 32'd0);
    check(0, "mid_rst_valid", 32'(ov0), 32'd0);
    rst = 1'b0; v1 = '1; ordy1 = 1'b1; tick();
    check(1, "post_rst_ch", 32'(oc1), 32'd0);

    // Randomized traffic.
    repeat (1500) begin
      v0 = 5'($urandom); v1 = 4'($urandom);
      ordy0 = ($urandom_range(0, 3) != 0); ordy1 = ($urandom_range(0, 3) != 0);
      sel0 = 3'($urandom); sel1 = 2'($urandom);
      d0 = 40'({$urandom, $urandom}); d1 = 32'($urandom);
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N-channel, WIDTH-bit stream multiplexer with valid/ready handshakes and one registered output stage.
- Successor to the 2:1 single-bit combinational mux. Adds channel count, data width, selectable arbitration mode and flow control.
- Sits between several producer streams (UART RX, counters, keypad scanner) and a single consumer (display driver, TX).

Parameters:
- N_CH, 4, number of input channels (2..16).
- WIDTH, 8, data width per channel (1..32).
- MODE, 0, arbitration mode: 0 = fixed select from sel port, 1 = round-robin.
- SEL_W, $clog2(N_CH), width of sel and out_ch (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_data  input  N_CH*WIDTH  packed channel data; channel i at bits [i*WIDTH +: WIDTH].
- in_valid  input  N_CH  per-channel valid.
- in_ready  output  N_CH  per-channel ready; combinational.
- sel  input  SEL_W  channel select; used only when MODE=0.
- out_data  output  WIDTH  registered output data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  consumer ready.
- out_ch  output  SEL_W  registered index of the channel that supplied out_data.

Behaviour:
- Reset (rst=1 at posedge) clears out_valid, out_data, out_ch and the rr pointer ptr to 0. Reset wins over any simultaneous transfer.
- load = !out_valid | out_ready. The output register may take a new word this cycle.
- Grant, combinational and one-hot or zero:
  - MODE 0: grant[sel] = in_valid[sel]. If sel >= N_CH, there is no grant.
  - MODE 1: lowest-index valid channel searching ptr, ptr+1, ..., wrapping modulo N_CH.
- in_ready[i] = load & grant[i]. At most one in_ready is high in any cycle. An input transfer occurs when in_valid[i] & in_ready[i].
- On an input transfer: out_data <= in_data[g], out_ch <= g, out_valid <= 1 at the next edge. Latency is 1 cycle.
- load=1 with no grant: out_valid <= 0 (if out_ready drained it); out_data and out_ch hold their values.
- Backpressure: out_valid=1 & out_ready=0 holds out_data, out_ch and out_valid stable, and drives all in_ready to 0.
- Full throughput: out_valid=1 & out_ready=1 with a grant delivers back-to-back words, one per cycle, with no bubble.
- Round-robin pointer: after a transfer from channel g, ptr <= (g == N_CH-1) ? 0 : g+1. ptr does not move without a transfer. ptr is unused in MODE 0.
- Fairness: in MODE 1 with all channels valid and out_ready=1, grants run 0,1,..,N_CH-1,0,...
- Changing sel while out_valid is held has no effect on the held word. The new sel applies at the next load.
- in_valid deasserting while the channel is not granted is legal. No data is consumed.
- Non-power-of-2 N_CH: pointer wrap and the sel range check use N_CH, not 2^SEL_W.

Decomposition:
- Package stream_mux_pkg:
  - MODE_FIXED=0, MODE_RR=1.
  - Function clog2_min1 (returns at least 1, so SEL_W is never 0).
- Sub-module rr_grant (N_CH): inputs req[N_CH] and ptr[SEL_W]; outputs grant one-hot and grant index. Purely combinational, instantiated only when MODE=1.
- Output register and ptr register live in the top module.

Test Plan:
- Reset: hold rst=1 for 2 cycles with in_valid=4'b1111 -> out_valid=0, out_data=0, out_ch=0, in_ready=0000. After release, the first word appears one cycle after the first load.
- MODE 0, sel=2, in_data ch2=8'hA5, in_valid=0100, out_ready=1 -> in_ready=0100; next cycle out_data=A5, out_ch=2, out_valid=1. Then sel=3 with in_valid[3]=0 -> out_valid drops to 0 the following cycle.
- MODE 1, all valid, ch data 10/20/30/40, out_ready=1 for 8 cycles -> out_data sequence 10,20,30,40,10,20,30,40, out_ch 0,1,2,3,0,1,2,3, no bubbles.
- Backpressure:
  - Setup: word 8'h3C held, out_ready=0 for 5 cycles.
  - Expected: out_data stays 3C, out_valid stays 1, in_ready=0000 throughout, ptr unchanged.
  - When out_ready rises: the next granted word appears after 1 cycle.
- MODE 1, ptr=3 after a ch2 grant, in_valid=0011 -> ch0 granted (wrap). Then ptr=1 and ch1 is granted next.
- Mid-stream reset: rst=1 while out_valid=1, out_ready=0, ptr=2 -> next cycle out_valid=0, ptr=0. The first post-reset grant in MODE 1 with in_valid=1111 goes to ch0.
